instr_fetch_unit: RTL



---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/load_reg.sv | 19 +
 rtl/instr_fetch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch unit and the CPU controller.
// Contents: fetch FSM state encodings, opcode/op constants, IR field
// bit positions and the sign_ext helper used by the decode outputs.
package cpu_pkg;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'b00,
      FS_ISSUE = 2'b01,
      FS_WAIT  = 2'b10,
      FS_HOLD  = 2'b11
   } fetch_state_e;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;
   localparam logic [2:0] OPC_STR = 3'b100;
   localparam logic [2:0] OPC_LDR = 3'b011;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_CMP = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_MVN = 2'b11;

   localparam int unsigned IR_W       = 16;
   localparam int unsigned IR_OPC_LSB = 13;
   localparam int unsigned IR_OP_LSB  = 11;
   localparam int unsigned IR_RN_LSB  = 8;
   localparam int unsigned IR_RD_LSB  = 5;
   localparam int unsigned IR_SH_LSB  = 3;
   localparam int unsigned IR_RM_LSB  = 0;

   // Replicate bit (width-1) of val into all bits at and above width.
   function automatic logic [15:0] sign_ext(input logic [15:0] val,
                                            input int unsigned width);
      logic [15:0] res;
      res = val;
      for (int unsigned i = 0; i < 16; i++) begin
         if (i >= width) res[4'(i)] = val[4'(width - 1)];
      end
      return res;
   endfunction

endpackage

// File: rtl/load_reg.sv
// load_reg: enable register with synchronous active-high reset value.
// Ports: clk, reset, en_i (load enable), d_i (load value), q_o (register).
module load_reg #(
   parameter int unsigned   W       = 8,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk) begin
      if (reset)     q_o <= RST_VAL;
      else if (en_i) q_o <= d_i;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns PC and IR, sequences the RAM read of each
// instruction and hands it to the controller via fetch_req/ir_valid/ir_ack.
// Ports: clk/reset; fetch_req, ir_ack (controller handshake); data_access,
// data_addr (datapath RAM access); pc_load, pc_new (PC load); mem_addr,
// mem_rd, mem_rdata (RAM); ir, ir_valid, pc, busy, conflict (status);
// opcode, op, rn, rd, shift, rm, sximm8, sximm5 (decoded IR fields).
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned MEM_LAT  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic              ir_ack,
   input  logic              data_access,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_new,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ir,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              conflict,
   output logic [2:0]        opcode,
   output logic [1:0]        op,
   output logic [2:0]        rn,
   output logic [2:0]        rd,
   output logic [1:0]        shift,
   output logic [2:0]        rm,
   output logic [15:0]       sximm8,
   output logic [15:0]       sximm5
);

   localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   fetch_state_e      state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ir_valid_q;
   logic              conflict_q;
   logic              mem_rd_q;
   logic              busy_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              pc_en;
   logic [DATA_W-1:0] ir_q;
   logic              capture_c;
   logic              idle_or_hold_c;

   assign capture_c      = (state_q == FS_WAIT) && (cnt_q == '0);
   assign idle_or_hold_c = (state_q == FS_IDLE) || (state_q == FS_HOLD);

   // PC next value: load only when no fetch is in flight, increment on capture.
   always_comb begin
      pc_en = 1'b0;
      pc_d  = pc_q;
      if (idle_or_hold_c && pc_load) begin
         pc_en = 1'b1;
         pc_d  = pc_new;
      end else if (capture_c) begin
         pc_en = 1'b1;
         pc_d  = pc_q + ADDR_W'(1);
      end
   end

   load_reg #(.W(ADDR_W), .RST_VAL(ADDR_W'(RESET_PC))) u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .en_i  (pc_en),
      .d_i   (pc_d),
      .q_o   (pc_q)
   );

   load_reg #(.W(DATA_W), .RST_VAL('0)) u_ir_reg (
      .clk   (clk),
      .reset (reset),
      .en_i  (capture_c),
      .d_i   (mem_rdata),
      .q_o   (ir_q)
   );

   // Fetch sequencer; mem_rd and busy are registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FS_IDLE;
         cnt_q      <= '0;
         ir_valid_q <= 1'b0;
         conflict_q <= 1'b0;
         mem_rd_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         mem_rd_q <= 1'b0;
         // A datapath access during a fetch loses the address mux; flag it.
         if (busy_q && data_access) conflict_q <= 1'b1;
         case (state_q)
            FS_IDLE: begin
               if (fetch_req) begin
                  state_q  <= FS_ISSUE;
                  mem_rd_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            FS_ISSUE: begin
               state_q <= FS_WAIT;
               cnt_q   <= CNT_W'(MEM_LAT - 1);
            end
            FS_WAIT: begin
               if (cnt_q == '0) begin
                  state_q    <= FS_HOLD;
                  ir_valid_q <= 1'b1;
                  busy_q     <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            FS_HOLD: begin
               if (ir_ack) begin
                  ir_valid_q <= 1'b0;
                  if (fetch_req) begin
                     state_q  <= FS_ISSUE;
                     mem_rd_q <= 1'b1;
                     busy_q   <= 1'b1;
                  end else begin
                     state_q <= FS_IDLE;
                  end
               end
            end
            default: state_q <= FS_IDLE;
         endcase
      end
   end

   // Datapath may steal the RAM address only while no fetch is in flight.
   assign mem_addr = (data_access && idle_or_hold_c) ? data_addr : pc_q;
   assign mem_rd   = mem_rd_q;
   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign pc       = pc_q;
   assign busy     = busy_q;
   assign conflict = conflict_q;

   // Decode taken from the IR register only.
   assign opcode = ir_q[IR_OPC_LSB +: 3];
   assign op     = ir_q[IR_OP_LSB  +: 2];
   assign rn     = ir_q[IR_RN_LSB  +: 3];
   assign rd     = ir_q[IR_RD_LSB  +: 3];
   assign shift  = ir_q[IR_SH_LSB  +: 2];
   assign rm     = ir_q[IR_RM_LSB  +: 3];
   assign sximm8 = sign_ext({8'b0, ir_q[7:0]}, 8);
   assign sximm5 = sign_ext({11'b0, ir_q[4:0]}, 5);

endmodule
